// File: rtl/slave_pkg.sv
// Shared defaults and helpers for the slave receive FIFO slice.
package slave_pkg;

    // Default data bus width in bits (legal range 1..64).
    localparam int DEF_DATA_W = 8;

    // Default FIFO depth in entries (power of two, at least 2).
    localparam int DEF_DEPTH  = 4;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/slave_rx_fifo_if.sv
// Handshake bundle for the slave receive FIFO: control, upstream and downstream channels.
interface slave_rx_fifo_if #(
    parameter int DATA_W = slave_pkg::DEF_DATA_W,
    parameter int DEPTH  = slave_pkg::DEF_DEPTH
);
    import slave_pkg::*;

    localparam int CNT_W = clog2(DEPTH) + 1;

    // Control
    logic              en;
    logic              flush;

    // Upstream (write) channel
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    // Downstream (read) channel
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    // Status
    logic [CNT_W-1:0]  count;

    // The FIFO itself sits on the slave side of this bundle.
    modport slave (
        input  en,
        input  flush,
        input  s_valid,
        input  s_data,
        input  m_ready,
        output s_ready,
        output m_valid,
        output m_data,
        output count
    );

    // Whatever drives the FIFO (producer, consumer and control).
    modport master (
        output en,
        output flush,
        output s_valid,
        output s_data,
        output m_ready,
        input  s_ready,
        input  m_valid,
        input  m_data,
        input  count
    );

endinterface

// File: rtl/slave_fifo_ram.sv
// FIFO storage: DEPTH x DATA_W array, synchronous write port, asynchronous read port.
// Contents are intentionally never reset; the controller only exposes written entries.
module slave_fifo_ram
    import slave_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write the addressed entry on a write strobe; other entries hold.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read of the addressed entry.
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/slave_rx_fifo.sv
// Slave receive FIFO: pointer, occupancy and handshake control around slave_fifo_ram.
// Ready/valid are decoded from registered occupancy only, so there is no
// combinational path from s_valid to m_valid and no same-cycle fall-through.
module slave_rx_fifo
    import slave_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    slave_rx_fifo_if.slave bus
);

    localparam int AW    = clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Registered state and next-state values
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    // Decoded status and handshake strobes
    logic              full;
    logic              empty;
    logic              s_ready;
    logic              m_valid;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_data;

    // Status and handshake decode from registered occupancy plus the live controls.
    // Flush and en gate s_ready directly, which also keeps the RAM from being
    // written during a flush cycle.
    always_comb begin
        full    = (count_q == FULL_CNT);
        empty   = (count_q == '0);
        s_ready = bus.en & ~full & ~bus.flush;
        m_valid = ~empty;
        push    = bus.s_valid & s_ready;
        pop     = m_valid & bus.m_ready;
    end

    // Next-state for pointers and occupancy; flush overrides any push or pop.
    // DEPTH is a power of two, so pointers wrap naturally from DEPTH-1 to 0.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous active-low reset; reset discards all entries.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    slave_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.s_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_data)
    );

    // Output drive; head data is masked to zero while empty so stale or
    // never-written storage is never visible.
    always_comb begin
        bus.s_ready = s_ready;
        bus.m_valid = m_valid;
        bus.m_data  = m_valid ? head_data : '0;
        bus.count   = count_q;
    end

endmodule

// File: tb/tb_slave_rx_fifo.sv
// Directed self-checking bench for slave_rx_fifo (DATA_W=8, DEPTH=4).
`timescale 1ns/1ps
module tb_slave_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst;

    int total;
    int bad;

    slave_rx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    slave_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1ns so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [7:0] d);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        tick();
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        rst         = 1'b0;
        bus.en      = 1'b1;
        bus.flush   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;

        // Reset state
        chk("rst_count",   64'(bus.count),   64'd0);
        chk("rst_m_valid", 64'(bus.m_valid), 64'd0);
        chk("rst_m_data",  64'(bus.m_data),  64'h00);
        chk("rst_s_ready", 64'(bus.s_ready), 64'd1);

        // Fill test with no fall-through check on the first push
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h11;
        #1;
        chk("nofall_m_valid", 64'(bus.m_valid), 64'd0);
        tick();
        chk("lat_m_valid", 64'(bus.m_valid), 64'd1);
        chk("lat_m_data",  64'(bus.m_data),  64'h11);
        push1(8'h22);
        push1(8'h33);
        push1(8'h44);
        chk("fill_count",   64'(bus.count),   64'd4);
        chk("fill_s_ready", 64'(bus.s_ready), 64'd0);
        chk("fill_m_data",  64'(bus.m_data),  64'h11);

        // Push attempt while full must be ignored
        push1(8'h55);
        chk("full_push_count",  64'(bus.count),  64'd4);
        chk("full_push_m_data", 64'(bus.m_data), 64'h11);

        // Drain test
        bus.m_ready = 1'b1;
        chk("drain0", 64'(bus.m_data), 64'h11);
        tick();
        chk("drain1", 64'(bus.m_data), 64'h22);
        tick();
        chk("drain2", 64'(bus.m_data), 64'h33);
        tick();
        chk("drain3", 64'(bus.m_data), 64'h44);
        tick();
        chk("drain_m_valid", 64'(bus.m_valid), 64'd0);
        chk("drain_m_data",  64'(bus.m_data),  64'h00);
        chk("drain_count",   64'(bus.count),   64'd0);
        tick();
        chk("empty_pop_count", 64'(bus.count), 64'd0);
        bus.m_ready = 1'b0;

        // Concurrent test: count=2 holding 01,02, then 10 push+pop cycles feeding 03..0C
        push1(8'h01);
        push1(8'h02);
        chk("conc_start_count", 64'(bus.count), 64'd2);
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.s_data = 8'(k + 3);
            #1;
            chk($sformatf("conc_head%0d", k), 64'(bus.m_data), 64'(k + 1));
            tick();
            chk($sformatf("conc_count%0d", k), 64'(bus.count), 64'd2);
        end
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        chk("conc_tail0", 64'(bus.m_data), 64'h0B);

        // Enable test: en low blocks pushes but entries still drain
        bus.en      = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hAA;
        #1;
        chk("en_s_ready", 64'(bus.s_ready), 64'd0);
        tick();
        chk("en_count_hold", 64'(bus.count), 64'd2);
        bus.m_ready = 1'b1;
        tick();
        chk("en_drain_data",  64'(bus.m_data), 64'h0C);
        chk("en_drain_count", 64'(bus.count),  64'd1);
        tick();
        chk("en_drain_empty", 64'(bus.m_valid), 64'd0);
        chk("en_drain_count0", 64'(bus.count), 64'd0);
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b0;
        bus.en      = 1'b1;
        #1;

        // Flush test: flush wins over a simultaneous push
        push1(8'h21);
        push1(8'h22);
        push1(8'h23);
        chk("flush_pre_count", 64'(bus.count), 64'd3);
        bus.flush   = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h99;
        #1;
        chk("flush_s_ready", 64'(bus.s_ready), 64'd0);
        tick();
        bus.flush   = 1'b0;
        bus.s_valid = 1'b0;
        #1;
        chk("flush_count",   64'(bus.count),   64'd0);
        chk("flush_m_valid", 64'(bus.m_valid), 64'd0);
        chk("flush_m_data",  64'(bus.m_data),  64'h00);
        push1(8'h31);
        chk("post_flush_data",  64'(bus.m_data), 64'h31);
        chk("post_flush_count", 64'(bus.count),  64'd1);
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;

        // Reset test: mid-transfer reset discards entries, no pop on reset edge
        push1(8'h41);
        push1(8'h42);
        push1(8'h43);
        chk("rst2_pre_count", 64'(bus.count), 64'd3);
        rst         = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        rst         = 1'b1;
        bus.m_ready = 1'b0;
        #1;
        chk("rst2_count",   64'(bus.count),   64'd0);
        chk("rst2_m_data",  64'(bus.m_data),  64'h00);
        chk("rst2_s_ready", 64'(bus.s_ready), 64'd1);
        bus.en = 1'b0;
        #1;
        chk("rst2_s_ready_en0", 64'(bus.s_ready), 64'd0);
        bus.en = 1'b1;
        push1(8'h51);
        chk("rst2_push_data", 64'(bus.m_data), 64'h51);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/slave_rx_fifo.md
SLAVE_RX_FIFO -- requirements
Module: slave_rx_fifo

Interface
REQ-001 Parameter DATA_W SHALL exist: default 8, data bus width in bits, legal range 1..64.
REQ-002 Parameter DEPTH SHALL exist: default 4, FIFO entry count, power of two, minimum 2.
REQ-003 Derived constant CNT_W SHALL equal log2(DEPTH)+1.
REQ-004 Port clk SHALL be an input, 1 bit: clock; all logic SHALL be on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: reset, synchronous, active-low.
REQ-006 Port en SHALL be an input, 1 bit: receive enable; when low, no new data is accepted.
REQ-007 Port flush SHALL be an input, 1 bit: synchronous clear of all stored entries.
REQ-008 Port s_valid SHALL be an input, 1 bit: upstream data valid.
REQ-009 Port s_ready SHALL be an output, 1 bit: this block can accept data.
REQ-010 Port s_data SHALL be an input, DATA_W bits: upstream data.
REQ-011 Port m_valid SHALL be an output, 1 bit: head entry available.
REQ-012 Port m_ready SHALL be an input, 1 bit: downstream accepts the head entry.
REQ-013 Port m_data SHALL be an output, DATA_W bits: head entry data.
REQ-014 Port count SHALL be an output, CNT_W bits: current occupancy, 0..DEPTH.

Function
REQ-015 s_ready SHALL equal en AND (count != DEPTH) AND NOT flush, decoded from registered state only.
REQ-016 A push SHALL occur on a clock edge where s_valid and s_ready are both high; s_data SHALL be written at the write pointer.
REQ-017 A pop SHALL occur on a clock edge where m_valid and m_ready are both high; the read pointer SHALL advance by one.
REQ-018 m_valid SHALL equal (count != 0).
REQ-019 m_data SHALL present the head entry when m_valid is high and SHALL be all-zero when m_valid is low.
REQ-020 Latency SHALL be one cycle: data pushed at edge N is visible on m_valid/m_data after edge N; there is no same-cycle fall-through.
REQ-021 A simultaneous push and pop SHALL leave count unchanged and SHALL advance both pointers.
REQ-022 Because s_ready is low when full, a push SHALL never occur while full, even if a pop occurs on the same edge.
REQ-023 A pop SHALL never occur while count is 0.
REQ-024 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-025 Flush high SHALL set count and both pointers to 0 at the next edge, with priority over any push or pop in that cycle.
REQ-026 Deasserting en SHALL drop s_ready in the same cycle; stored entries SHALL continue to drain through the m_* interface.
REQ-027 Once a pushed entry is stored, it SHALL not be altered by s_data, s_valid or en.
REQ-028 Popped entries SHALL be returned in strict FIFO order, with no loss or duplication.

Reset
REQ-029 While rst is low at a clock edge, count, both pointers and all status logic SHALL be cleared.
REQ-030 After reset, outputs SHALL be: s_ready = en; m_valid = 0; m_data = 0; count = 0.
REQ-031 Storage array contents SHALL not be reset and SHALL be unobservable until written.
REQ-032 Reset asserted mid-transfer SHALL discard all entries; no pop SHALL occur on the reset edge.

Structure
REQ-033 Package slave_pkg SHALL hold the DATA_W and DEPTH default constants and a clog2 helper function.
REQ-034 Storage SHALL be a sub-module slave_fifo_ram: DEPTH x DATA_W, one synchronous write port and one asynchronous read port.
REQ-035 Pointer, count and handshake logic SHALL reside in slave_rx_fifo.

Verification
REQ-036 Fill test: after reset with en=1, push 0x11,0x22,0x33,0x44 with m_ready=0 -> count=4, s_ready=0, m_data=0x11.
REQ-037 Drain test: from the full state, set m_ready=1 -> outputs 0x11,0x22,0x33,0x44 on consecutive cycles, then m_valid=0, m_data=0x00.
REQ-038 Concurrent test: with count=2, push and pop together for 10 cycles -> count stays 2; wrap-around occurs; order is preserved.
REQ-039 Enable test: with en=0 and s_valid=1, s_data=0xAA -> s_ready=0, count unchanged; existing entries still drain.
REQ-040 Flush test: with count=3, assert flush together with s_valid=1 -> count=0 and m_valid=0 next cycle; the pushed data is not stored.
REQ-041 Reset test: with count=3, pull rst low for one cycle -> count=0, m_data=0, s_ready=en.
